uart_xcvr: RTL and testbench
============================

Name: uart_xcvr

Overview:
Parametrised UART transceiver with valid/ready byte streams, TX and RX FIFOs, and optional parity, plus framing, parity and overflow error flags. It is the synthesizable successor to the fixed 8N1 virtual-UART link in the Verilator top. It sits between a bus-side peripheral wrapper (or testbench) and the uart_rx/uart_tx pins, in both the simulation top and the FPGA top.

Parameters:
ClockFrequency, 50_000_000, clk_i frequency in Hz.
BaudRate, 115_200, line rate in bits per second. ClksPerBit = ClockFrequency/BaudRate (integer divide); elaboration error if < 4.
DataBits, 8, data bits per frame; legal range 5..8.
ParityEn, 0, 1 adds a parity bit after the data bits.
ParityOdd, 0, 1 selects odd parity, 0 selects even; ignored if ParityEn=0.
StopBits, 1, number of stop bits; 1 or 2.
FifoDepth, 4, entries in each of the TX and RX FIFOs; power of 2, at least 2.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  asynchronous active-low reset.
tx_valid_i  in  1  TX byte offered.
tx_data_i  in  DataBits  TX byte.
tx_ready_o  out  1  TX FIFO not full.
rx_valid_o  out  1  RX FIFO not empty.
rx_data_o  out  DataBits  head of RX FIFO.
rx_ready_i  in  1  consumer pops the RX head.
tx_idle_o  out  1  TX FIFO empty and TX shifter idle.
rx_frame_err_o  out  1  one-cycle pulse: stop bit sampled 0.
rx_parity_err_o  out  1  one-cycle pulse: parity mismatch.
rx_overflow_o  out  1  one-cycle pulse: received byte dropped because the RX FIFO is full.
uart_rx_i  in  1  serial input; asynchronous to clk_i.
uart_tx_o  out  1  serial output; idles high.

Behaviour:
- Clocking and reset: single clock clk_i. rst_ni is asynchronous assert, active-low. Reset values: uart_tx_o=1, tx_ready_o=1, rx_valid_o=0, tx_idle_o=1, all error pulses 0, both FIFOs empty, both FSMs in IDLE. Assertion mid-frame aborts the frame immediately and drives the line high.
- Handshakes:
  - TX push when tx_valid_i && tx_ready_o. RX pop when rx_valid_o && rx_ready_i.
  - rx_data_o is stable while rx_valid_o=1 and no pop occurs.
  - Push and pop in the same cycle are both honoured.
- TX FIFO to shifter: the shifter takes an entry when in IDLE and the FIFO is non-empty. The start bit appears on uart_tx_o the cycle after the pop. Minimum push-to-start-bit latency is 2 cycles.
- TX FSM:
  - States IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each bit lasts exactly ClksPerBit cycles, counted by a down-counter reloaded at each bit boundary.
  - Data is sent LSB first.
  - Parity bit = XOR of the data bits, inverted if ParityOdd.
  - STOP lasts StopBits*ClksPerBit cycles.
  - Back-to-back frames: the next start bit follows the last stop cycle with no idle gap.
- RX input: uart_rx_i passes through a 2-flop synchroniser (reset value 1) before any use.
- RX FSM:
  - States IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a falling edge (synced 1->0) loads the counter with ClksPerBit/2.
  - START: at count 0, re-sample the line. If it is 1 (glitch), return to IDLE with no error. Otherwise proceed, and sample each subsequent bit every ClksPerBit cycles (mid-bit).
  - STOP: only the first stop bit is checked.
  - At the STOP sample:
    - If the stop bit is 0, pulse rx_frame_err_o, discard the byte, and wait in IDLE until the line is 1. This handles break conditions.
    - Else, on parity mismatch, pulse rx_parity_err_o and discard the byte.
    - Else, if the RX FIFO is full, pulse rx_overflow_o and discard the byte; existing contents are kept.
    - Else, push the byte. rx_valid_o rises the next cycle.
  - After the STOP sample, return to IDLE. Re-arm is immediate, so frames may abut.
- FIFO: full/empty via pointers one bit wider than log2(FifoDepth); wrap-around is natural. Full reports tx_ready_o=0. A push while full is impossible (TX) or dropped with rx_overflow_o (RX).
- ClksPerBit counter width: $clog2(ClksPerBit+1).

Decomposition:
- Package uart_pkg holds:
  - TX and RX FSM state enums.
  - A function returning parity for a DataBits-wide value plus an odd flag.
  - A ClksPerBit helper function.
- One sub-module, uart_fifo (parametrised Width and Depth, valid/ready both sides, registered storage), instantiated twice.
- The TX and RX FSMs stay inline in uart_xcvr.

Test Plan:
All scenarios use ClockFrequency=16 and BaudRate=1, giving ClksPerBit=16.
- 8N1 TX, push 0xA5 -> uart_tx_o: start 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 (16 cycles each), then stop 1. tx_idle_o returns to 1 exactly 160 cycles after the start bit begins.
- Loopback (uart_tx_o to uart_rx_i) with DataBits=7, ParityEn=1, ParityOdd=1, StopBits=2; push 0x00,0x7F,0x55 -> rx_data_o yields 0x00,0x7F,0x55 in order, no error pulses, and frames abut with no gap.
- RX with an even-parity frame whose parity bit is forced wrong on 0x03 -> one rx_parity_err_o pulse, rx_valid_o stays 0.
- RX frame with stop bit driven 0, then the line held 0 for 100 cycles -> exactly one rx_frame_err_o pulse, no spurious start detected until the line returns to 1.
- FifoDepth=4, rx_ready_i=0, five frames received -> rx_valid_o=1 with 4 entries. The fifth frame gives one rx_overflow_o pulse, and the first pop returns byte 1.
- Reset asserted in the middle of TX data bit 3 -> uart_tx_o=1 and tx_ready_o=1 in the same cycle. After release, a new push transmits cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver: FSM state encodings,
// bit-period arithmetic and the parity function used by both directions.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; full/empty come from
// pointers carrying one extra wrap bit.
module uart_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_valid_i,
  input  logic [Width-1:0] push_data_i,
  output logic             push_ready_o,
  output logic             pop_valid_o,
  output logic [Width-1:0] pop_data_o,
  input  logic             pop_ready_i
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = push_valid_i && !w_full;
  assign w_pop   = pop_ready_i && !w_empty;

  assign push_ready_o = !w_full;
  assign pop_valid_o  = !w_empty;
  assign pop_data_o   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_xcvr.sv
// UART transceiver: TX FIFO feeding a serialiser, and a mid-bit sampling
// receiver feeding an RX FIFO, with one-cycle framing/parity/overflow flags.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int DataBits       = 8,
  parameter int ParityEn       = 0,
  parameter int ParityOdd      = 0,
  parameter int StopBits       = 1,
  parameter int FifoDepth      = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tx_valid_i,
  input  logic [DataBits-1:0] tx_data_i,
  output logic                tx_ready_o,
  output logic                rx_valid_o,
  output logic [DataBits-1:0] rx_data_o,
  input  logic                rx_ready_i,
  output logic                tx_idle_o,
  output logic                rx_frame_err_o,
  output logic                rx_parity_err_o,
  output logic                rx_overflow_o,
  input  logic                uart_rx_i,
  output logic                uart_tx_o
);

  localparam int              ClksPerBit = clks_per_bit(ClockFrequency, BaudRate);
  localparam int              CntW       = $clog2(ClksPerBit + 1);
  localparam logic [CntW-1:0] CntBit     = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf    = CntW'(ClksPerBit / 2);
  localparam logic [2:0]      LastData   = 3'(DataBits - 1);
  localparam logic [2:0]      LastStop   = 3'(StopBits - 1);
  localparam logic            ParOdd     = (ParityOdd != 0);

  if (ClksPerBit < 4) begin : g_err_cpb
    $error("uart_xcvr: ClksPerBit must be at least 4");
  end
  if (DataBits < 5 || DataBits > 8) begin : g_err_bits
    $error("uart_xcvr: DataBits must be 5..8");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_err_stop
    $error("uart_xcvr: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_err_depth
    $error("uart_xcvr: FifoDepth must be a power of 2, at least 2");
  end

  logic                w_txf_valid;
  logic [DataBits-1:0] w_txf_data;
  logic                w_tx_last_stop;
  logic                w_tx_take;
  tx_state_e           r_tx_state;
  logic [CntW-1:0]     r_tx_cnt;
  logic [DataBits-1:0] r_tx_shift;
  logic [2:0]          r_tx_idx;
  logic                r_tx_par;
  logic                r_tx_line;

  uart_fifo #(.Width(DataBits), .Depth(FifoDepth)) u_tx_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_valid_i(tx_valid_i),
    .push_data_i (tx_data_i),
    .push_ready_o(tx_ready_o),
    .pop_valid_o (w_txf_valid),
    .pop_data_o  (w_txf_data),
    .pop_ready_i (w_tx_take)
  );

  // Taking the next entry on the last stop cycle lets frames abut with no idle gap.
  assign w_tx_last_stop = (r_tx_state == TX_STOP) && (r_tx_cnt == '0) && (r_tx_idx == LastStop);
  assign w_tx_take      = w_txf_valid && ((r_tx_state == TX_IDLE) || w_tx_last_stop);
  assign tx_idle_o      = (r_tx_state == TX_IDLE) && !w_txf_valid;
  assign uart_tx_o      = r_tx_line;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
    end else if (w_tx_take) begin
      r_tx_state <= TX_START;
      r_tx_cnt   <= CntBit;
      r_tx_shift <= w_txf_data;
      r_tx_par   <= calc_parity(8'(w_txf_data), ParOdd);
      r_tx_line  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: r_tx_line <= 1'b1;
        TX_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_line  <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_idx   <= '0;
            r_tx_cnt   <= CntBit;
            r_tx_state <= TX_DATA;
          end else r_tx_cnt <= r_tx_cnt - 1'b1;
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= CntBit;
            if (r_tx_idx == LastData) begin
              r_tx_idx <= '0;
              if (ParityEn != 0) begin
                r_tx_line  <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                r_tx_line  <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_line  <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_idx   <= r_tx_idx + 3'd1;
            end
          end else r_tx_cnt <= r_tx_cnt - 1'b1;
        end
        TX_PARITY: begin
          if (r_tx_cnt == '0) begin
            r_tx_line  <= 1'b1;
            r_tx_cnt   <= CntBit;
            r_tx_idx   <= '0;
            r_tx_state <= TX_STOP;
          end else r_tx_cnt <= r_tx_cnt - 1'b1;
        end
        TX_STOP: begin
          if (r_tx_cnt == '0) begin
            if (r_tx_idx == LastStop) r_tx_state <= TX_IDLE;
            else begin
              r_tx_idx <= r_tx_idx + 3'd1;
              r_tx_cnt <= CntBit;
            end
          end else r_tx_cnt <= r_tx_cnt - 1'b1;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  logic                r_rx_sync1;
  logic                r_rx_sync2;
  logic                r_rx_prev;
  rx_state_e           r_rx_state;
  logic [CntW-1:0]     r_rx_cnt;
  logic [DataBits-1:0] r_rx_shift;
  logic [2:0]          r_rx_idx;
  logic                r_rx_parbit;
  logic                r_frame_err;
  logic                r_parity_err;
  logic                r_overflow;
  logic                w_rxf_ready;
  logic                w_rx_sample;
  logic                w_rx_par_ok;
  logic                w_rx_push;

  assign w_rx_sample = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);
  assign w_rx_par_ok = (ParityEn == 0) || (r_rx_parbit == calc_parity(8'(r_rx_shift), ParOdd));
  assign w_rx_push   = w_rx_sample && r_rx_sync2 && w_rx_par_ok && w_rxf_ready;

  assign rx_frame_err_o  = r_frame_err;
  assign rx_parity_err_o = r_parity_err;
  assign rx_overflow_o   = r_overflow;

  uart_fifo #(.Width(DataBits), .Depth(FifoDepth)) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_valid_i(w_rx_push),
    .push_data_i (r_rx_shift),
    .push_ready_o(w_rxf_ready),
    .pop_valid_o (rx_valid_o),
    .pop_data_o  (rx_data_o),
    .pop_ready_i (rx_ready_i)
  );

  // A start needs a 1->0 edge, so after a framing error a held-low break is ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_sync1   <= 1'b1;
      r_rx_sync2   <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_shift   <= '0;
      r_rx_idx     <= '0;
      r_rx_parbit  <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_rx_sync1   <= uart_rx_i;
      r_rx_sync2   <= r_rx_sync1;
      r_rx_prev    <= r_rx_sync2;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync2) begin
            r_rx_cnt   <= CntHalf;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_sync2) r_rx_state <= RX_IDLE;
            else begin
              r_rx_cnt   <= CntBit;
              r_rx_idx   <= '0;
              r_rx_state <= RX_DATA;
            end
          end else r_rx_cnt <= r_rx_cnt - 1'b1;
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {r_rx_sync2, r_rx_shift[DataBits-1:1]};
            r_rx_cnt   <= CntBit;
            if (r_rx_idx == LastData) begin
              r_rx_idx   <= '0;
              r_rx_state <= (ParityEn != 0) ? RX_PARITY : RX_STOP;
            end else r_rx_idx <= r_rx_idx + 3'd1;
          end else r_rx_cnt <= r_rx_cnt - 1'b1;
        end
        RX_PARITY: begin
          if (r_rx_cnt == '0) begin
            r_rx_parbit <= r_rx_sync2;
            r_rx_cnt    <= CntBit;
            r_rx_state  <= RX_STOP;
          end else r_rx_cnt <= r_rx_cnt - 1'b1;
        end
        RX_STOP: begin
          if (r_rx_cnt == '0) begin
            r_rx_state <= RX_IDLE;
            if (!r_rx_sync2)       r_frame_err  <= 1'b1;
            else if (!w_rx_par_ok) r_parity_err <= 1'b1;
            else if (!w_rxf_ready) r_overflow   <= 1'b1;
          end else r_rx_cnt <= r_rx_cnt - 1'b1;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Bench for uart_xcvr at 16 clocks per bit: an 8N1 instance (A), a 7O2
// loopback instance (B) and an 8E1 receive-only instance (C).
module tb_uart_xcvr;

  typedef struct {
    int         pushCyc;
    logic [7:0] data;
  } txEv_t;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         numChecks = 0;
  int         numErrors = 0;
  txEv_t      qA[$];
  txEv_t      qB[$];
  logic [6:0] gotB[$];
  logic       enA = 1'b0;
  logic       enB = 1'b0;
  int         lastPush = 0;
  int         feA = 0, peA = 0, ovA = 0, feC = 0, peC = 0;

  logic       txValidA = 1'b0, txReadyA, rxValidA, rxReadyA = 1'b0, txIdleA;
  logic [7:0] txDataA = '0, rxDataA;
  logic       feOutA, peOutA, ovOutA, rxLineA = 1'b1, uartTxA;

  logic       txValidB = 1'b0, txReadyB, rxValidB, txIdleB;
  logic [6:0] txDataB = '0, rxDataB;
  logic       feOutB, peOutB, ovOutB, uartTxB;

  logic       txReadyC, rxValidC, txIdleC;
  logic [7:0] rxDataC;
  logic       feOutC, peOutC, ovOutC, rxLineC = 1'b1, uartTxC;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  uart_xcvr #(.ClockFrequency(16), .BaudRate(1)) dutA (
    .clk_i(clk_i), .rst_ni(rst_n), .tx_valid_i(txValidA), .tx_data_i(txDataA),
    .tx_ready_o(txReadyA), .rx_valid_o(rxValidA), .rx_data_o(rxDataA), .rx_ready_i(rxReadyA),
    .tx_idle_o(txIdleA), .rx_frame_err_o(feOutA), .rx_parity_err_o(peOutA),
    .rx_overflow_o(ovOutA), .uart_rx_i(rxLineA), .uart_tx_o(uartTxA)
  );

  uart_xcvr #(.ClockFrequency(16), .BaudRate(1), .DataBits(7), .ParityEn(1),
              .ParityOdd(1), .StopBits(2)) dutB (
    .clk_i(clk_i), .rst_ni(rst_n), .tx_valid_i(txValidB), .tx_data_i(txDataB),
    .tx_ready_o(txReadyB), .rx_valid_o(rxValidB), .rx_data_o(rxDataB), .rx_ready_i(1'b1),
    .tx_idle_o(txIdleB), .rx_frame_err_o(feOutB), .rx_parity_err_o(peOutB),
    .rx_overflow_o(ovOutB), .uart_rx_i(uartTxB), .uart_tx_o(uartTxB)
  );

  uart_xcvr #(.ClockFrequency(16), .BaudRate(1), .ParityEn(1), .ParityOdd(0)) dutC (
    .clk_i(clk_i), .rst_ni(rst_n), .tx_valid_i(1'b0), .tx_data_i(8'h00),
    .tx_ready_o(txReadyC), .rx_valid_o(rxValidC), .rx_data_o(rxDataC), .rx_ready_i(1'b0),
    .tx_idle_o(txIdleC), .rx_frame_err_o(feOutC), .rx_parity_err_o(peOutC),
    .rx_overflow_o(ovOutC), .uart_rx_i(rxLineC), .uart_tx_o(uartTxC)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level and idle flag derived from frame timing: each frame starts one
  // cycle after its push or right when the previous frame ends, whichever is later.
  function automatic void modelTx(input int which, input int c, output logic line, output logic idle);
    txEv_t      q[$];
    int         nD, pEn, nS, frameLen, prevEnd, s, e, b;
    logic       pOdd;
    logic [7:0] d;
    if (which == 0) begin
      q = qA; nD = 8; pEn = 0; pOdd = 1'b0; nS = 1;
    end else begin
      q = qB; nD = 7; pEn = 1; pOdd = 1'b1; nS = 2;
    end
    frameLen = 16 * (1 + nD + pEn + nS);
    line = 1'b1;
    idle = 1'b1;
    prevEnd = 0;
    foreach (q[i]) begin
      s = (q[i].pushCyc + 1 > prevEnd) ? q[i].pushCyc + 1 : prevEnd;
      e = s + frameLen;
      if (c >= q[i].pushCyc && c < e) idle = 1'b0;
      if (c >= s && c < e) begin
        b = (c - s) / 16;
        d = q[i].data;
        if (b == 0) line = 1'b0;
        else if (b <= nD) line = d[b-1];
        else if (pEn != 0 && b == nD + 1) line = (^d) ^ pOdd;
        else line = 1'b1;
      end
      prevEnd = e;
    end
  endfunction

  logic mLine, mIdle;
  always @(negedge clk_i) begin
    if (enA) begin
      modelTx(0, cyc, mLine, mIdle);
      checkOutput("txLineA", 32'(uartTxA), 32'(mLine));
      checkOutput("txIdleA", 32'(txIdleA), 32'(mIdle));
    end
    if (enB) begin
      modelTx(1, cyc, mLine, mIdle);
      checkOutput("txLineB", 32'(uartTxB), 32'(mLine));
      checkOutput("txIdleB", 32'(txIdleB), 32'(mIdle));
      checkOutput("errPulsesB", 32'({feOutB, peOutB, ovOutB}), 32'd0);
    end
  end

  always @(negedge clk_i) begin
    if (rst_n) begin
      feA += int'(feOutA); peA += int'(peOutA); ovA += int'(ovOutA);
      feC += int'(feOutC); peC += int'(peOutC);
      if (rxValidB) gotB.push_back(rxDataB);
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic toNeg(input int c);
    @(negedge clk_i);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic pushTx(input int which, input logic [7:0] d);
    int guard = 0;
    @(posedge clk_i); #1;
    while (((which == 0) ? txReadyA : txReadyB) !== 1'b1 && guard < 2000) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (guard >= 2000) checkOutput("txReadyTimeout", 32'd0, 32'd1);
    if (which == 0) begin txValidA = 1'b1; txDataA = d; end
    else begin txValidB = 1'b1; txDataB = d[6:0]; end
    @(posedge clk_i); #1;
    lastPush = cyc;
    if (which == 0) begin txValidA = 1'b0; qA.push_back('{pushCyc: cyc, data: d}); end
    else begin txValidB = 1'b0; qB.push_back('{pushCyc: cyc, data: {1'b0, d[6:0]}}); end
  endtask

  task automatic setRx(input int which, input logic v);
    if (which == 0) rxLineA = v; else rxLineC = v;
  endtask

  task automatic sendRxFrame(input int which, input logic [7:0] d, input logic hasPar,
                             input logic parBit, input logic stopVal);
    @(posedge clk_i); #1;
    setRx(which, 1'b0); waitCycles(16);
    for (int i = 0; i < 8; i++) begin
      setRx(which, d[i]); waitCycles(16);
    end
    if (hasPar) begin setRx(which, parBit); waitCycles(16); end
    setRx(which, stopVal); waitCycles(16);
  endtask

  task automatic popA(input logic [7:0] exp, input string name);
    @(negedge clk_i);
    checkOutput({name, "Valid"}, 32'(rxValidA), 32'd1);
    checkOutput({name, "Data"}, 32'(rxDataA), 32'(exp));
    rxReadyA = 1'b1;
    @(posedge clk_i); #1;
    rxReadyA = 1'b0;
  endtask

  task automatic applyStimulus();
    int s;
    logic [7:0] ovBytes [5];
    logic [6:0] loopBytes [3];
    ovBytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    loopBytes = '{7'h00, 7'h7F, 7'h55};

    waitCycles(3);
    checkOutput("rstTxLine", 32'(uartTxA), 32'd1);
    checkOutput("rstTxReady", 32'(txReadyA), 32'd1);
    checkOutput("rstRxValid", 32'(rxValidA), 32'd0);
    checkOutput("rstTxIdle", 32'(txIdleA), 32'd1);
    checkOutput("rstErrs", 32'({feOutA, peOutA, ovOutA}), 32'd0);
    rst_n = 1'b1;
    waitCycles(3);

    $display("[TB] 8N1 transmit of 0xA5");
    enA = 1'b1;
    pushTx(0, 8'hA5);
    s = lastPush + 1;
    toNeg(s);       checkOutput("a5StartBit", 32'(uartTxA), 32'd0);
    toNeg(s + 24);  checkOutput("a5Bit0", 32'(uartTxA), 32'd1);
    toNeg(s + 40);  checkOutput("a5Bit1", 32'(uartTxA), 32'd0);
    toNeg(s + 152); checkOutput("a5Stop", 32'(uartTxA), 32'd1);
    toNeg(s + 159); checkOutput("a5IdleBefore", 32'(txIdleA), 32'd0);
    toNeg(s + 160); checkOutput("a5IdleAfter", 32'(txIdleA), 32'd1);

    $display("[TB] 7O2 loopback");
    enB = 1'b1;
    foreach (loopBytes[i]) pushTx(1, {1'b0, loopBytes[i]});
    waitCycles(600);
    checkOutput("loopCount", 32'(gotB.size()), 32'd3);
    foreach (loopBytes[i])
      if (i < gotB.size()) checkOutput("loopData", 32'(gotB[i]), 32'(loopBytes[i]));
    enB = 1'b0;

    $display("[TB] even-parity receive with bad parity");
    sendRxFrame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    waitCycles(20);
    checkOutput("parErrCount", 32'(peC), 32'd1);
    checkOutput("parRxValid", 32'(rxValidC), 32'd0);
    checkOutput("parFrameErr", 32'(feC), 32'd0);
    sendRxFrame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    waitCycles(20);
    checkOutput("parGoodValid", 32'(rxValidC), 32'd1);
    checkOutput("parGoodData", 32'(rxDataC), 32'h07);
    checkOutput("parErrStill", 32'(peC), 32'd1);

    $display("[TB] framing error and break");
    sendRxFrame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    waitCycles(100);
    checkOutput("breakFrameErr", 32'(feA), 32'd1);
    checkOutput("breakRxValid", 32'(rxValidA), 32'd0);
    setRx(0, 1'b1);
    waitCycles(20);
    checkOutput("breakNoExtra", 32'(feA), 32'd1);
    sendRxFrame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    waitCycles(20);
    popA(8'h3C, "afterBreak");
    @(negedge clk_i);
    checkOutput("afterBreakEmpty", 32'(rxValidA), 32'd0);
    checkOutput("afterBreakErrs", 32'(feA + peA + ovA), 32'd1);

    $display("[TB] receive overflow");
    foreach (ovBytes[i]) begin
      sendRxFrame(0, ovBytes[i], 1'b0, 1'b0, 1'b1);
      waitCycles(4);
    end
    waitCycles(20);
    checkOutput("ovfCount", 32'(ovA), 32'd1);
    for (int i = 0; i < 4; i++) popA(ovBytes[i], "ovfPop");
    @(negedge clk_i);
    checkOutput("ovfDrained", 32'(rxValidA), 32'd0);

    $display("[TB] reset during data bit 3");
    pushTx(0, 8'hA5);
    s = lastPush + 1;
    toNeg(s + 72);
    checkOutput("midBit3", 32'(uartTxA), 32'd0);
    #2;
    enA = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abortTxLine", 32'(uartTxA), 32'd1);
    checkOutput("abortTxReady", 32'(txReadyA), 32'd1);
    checkOutput("abortTxIdle", 32'(txIdleA), 32'd1);
    qA.delete();
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(2);
    enA = 1'b1;
    pushTx(0, 8'h3C);
    waitCycles(200);
    checkOutput("postResetIdle", 32'(txIdleA), 32'd1);
    enA = 1'b0;
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
